// File: rtl/lap_stopwatch.sv
// lap_stopwatch
// Stopwatch / countdown timer with BCD M:SS.d digits, a pause/resume FSM
// and a circular lap buffer with read-back.
//
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   start_stop, lap, clear  - single-cycle control pulses
//   count_down              - 1 = countdown mode (latched when leaving IDLE)
//   load_min/sech/secl/tenth - countdown preset digits (clamped on load)
//   view_lap, lap_sel       - show stored lap (index 0 = oldest) instead of live time
//   minutes..tenths         - registered BCD display digits
//   running, expired        - state decodes
//   lap_count               - number of valid laps, saturating at LAP_DEPTH
module lap_stopwatch #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int LAP_DEPTH = 4,
  parameter int MIN_MAX   = 9,
  localparam int LW       = $clog2(LAP_DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start_stop,
  input  logic          lap,
  input  logic          clear,
  input  logic          count_down,
  input  logic [3:0]    load_min,
  input  logic [3:0]    load_sech,
  input  logic [3:0]    load_secl,
  input  logic [3:0]    load_tenth,
  input  logic          view_lap,
  input  logic [LW-1:0] lap_sel,
  output logic [3:0]    minutes,
  output logic [3:0]    sec_high,
  output logic [3:0]    sec_low,
  output logic [3:0]    tenths,
  output logic          running,
  output logic          expired,
  output logic [LW:0]   lap_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    MIN_TOP   = 4'(MIN_MAX);
  localparam logic [LW:0]   LAP_FULL  = (LW+1)'(LAP_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSE   = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  // Live time packed as {minutes, sec_high, sec_low, tenths}.
  logic [15:0]   time_q, time_d;
  logic [LW-1:0] wrPtr_q, wrPtr_d;
  logic [LW:0]   lapCnt_q, lapCnt_d;
  logic [15:0]   lapMem_q [LAP_DEPTH];
  logic [15:0]   disp_q, disp_d;
  logic          lapWe;

  logic          tick;
  logic [15:0]   timeInc, timeDec, preset, selLap;
  logic [LW-1:0] rdIdx;

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX);

  // Preset digits clamped to their legal range maximum.
  always_comb begin
    preset[15:12] = (load_min   > MIN_TOP) ? MIN_TOP : load_min;
    preset[11:8]  = (load_sech  > 4'd5)    ? 4'd5    : load_sech;
    preset[7:4]   = (load_secl  > 4'd9)    ? 4'd9    : load_secl;
    preset[3:0]   = (load_tenth > 4'd9)    ? 4'd9    : load_tenth;
  end

  // Ripple increment: MIN_MAX:59.9 wraps to 0:00.0.
  always_comb begin
    logic cT, cL, cH;
    cT = (time_q[3:0] == 4'd9);
    cL = cT && (time_q[7:4] == 4'd9);
    cH = cL && (time_q[11:8] == 4'd5);
    timeInc[3:0]   = cT ? 4'd0 : time_q[3:0] + 4'd1;
    timeInc[7:4]   = cT ? ((time_q[7:4] == 4'd9) ? 4'd0 : time_q[7:4] + 4'd1) : time_q[7:4];
    timeInc[11:8]  = cL ? ((time_q[11:8] == 4'd5) ? 4'd0 : time_q[11:8] + 4'd1) : time_q[11:8];
    timeInc[15:12] = cH ? ((time_q[15:12] == MIN_TOP) ? 4'd0 : time_q[15:12] + 4'd1) : time_q[15:12];
  end

  // Ripple decrement with borrow; a zero result is caught by the FSM before
  // any borrow out of minutes can matter.
  always_comb begin
    logic bT, bL, bH;
    bT = (time_q[3:0] == 4'd0);
    bL = bT && (time_q[7:4] == 4'd0);
    bH = bL && (time_q[11:8] == 4'd0);
    timeDec[3:0]   = bT ? 4'd9 : time_q[3:0] - 4'd1;
    timeDec[7:4]   = bT ? ((time_q[7:4] == 4'd0) ? 4'd9 : time_q[7:4] - 4'd1) : time_q[7:4];
    timeDec[11:8]  = bL ? ((time_q[11:8] == 4'd0) ? 4'd5 : time_q[11:8] - 4'd1) : time_q[11:8];
    timeDec[15:12] = bH ? ((time_q[15:12] == 4'd0) ? MIN_TOP : time_q[15:12] - 4'd1) : time_q[15:12];
  end

  // FSM, prescaler, digit and lap-pointer next state. clear overrides all.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    presc_d  = presc_q;
    time_d   = time_q;
    wrPtr_d  = wrPtr_q;
    lapCnt_d = lapCnt_q;
    lapWe    = 1'b0;
    if (clear) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      time_d   = '0;
      wrPtr_d  = '0;
      lapCnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_stop) begin
            presc_d = '0;
            mode_d  = count_down;
            if (count_down) begin
              time_d  = preset;
              state_d = (preset == 16'h0000) ? S_EXPIRED : S_RUN;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_d = '0;
            time_d  = mode_q ? timeDec : timeInc;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          // Reaching zero in countdown takes precedence over a pause request.
          if (tick && mode_q && (timeDec == 16'h0000)) begin
            state_d = S_EXPIRED;
          end else if (start_stop) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_stop) begin
            state_d = S_RUN;
          end
        end
        default: begin
        end
      endcase
      // Laps capture the pre-update time; the oldest entry is overwritten when full.
      if (lap && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
        lapWe   = 1'b1;
        wrPtr_d = wrPtr_q + 1'b1;
        if (lapCnt_q != LAP_FULL) begin
          lapCnt_d = lapCnt_q + 1'b1;
        end
      end
    end
  end

  // Lap index 0 maps to the oldest retained entry; unused indices read as zero.
  assign rdIdx  = wrPtr_q - lapCnt_q[LW-1:0] + lap_sel;
  assign selLap = ({1'b0, lap_sel} < lapCnt_q) ? lapMem_q[rdIdx] : 16'h0000;
  assign disp_d = view_lap ? selLap : time_q;

  // State, counters and registered display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      presc_q  <= '0;
      time_q   <= '0;
      wrPtr_q  <= '0;
      lapCnt_q <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      wrPtr_q  <= wrPtr_d;
      lapCnt_q <= lapCnt_d;
      disp_q   <= disp_d;
    end
  end

  // Lap buffer storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) begin
        lapMem_q[i] <= '0;
      end
    end else if (lapWe) begin
      lapMem_q[wrPtr_q] <= time_q;
    end
  end

  assign minutes   = disp_q[15:12];
  assign sec_high  = disp_q[11:8];
  assign sec_low   = disp_q[7:4];
  assign tenths    = disp_q[3:0];
  assign running   = (state_q == S_RUN);
  assign expired   = (state_q == S_EXPIRED);
  assign lap_count = lapCnt_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch
// Directed test of lap_stopwatch with TICK_DIV=4, LAP_DEPTH=4, MIN_MAX=9.
// Expected display words are written as {minutes, sec_high, sec_low, tenths}.
module tb_lap_stopwatch;

  logic       clock;
  logic       reset;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic       count_down;
  logic [3:0] load_min;
  logic [3:0] load_sech;
  logic [3:0] load_secl;
  logic [3:0] load_tenth;
  logic       view_lap;
  logic [1:0] lap_sel;
  logic [3:0] minutes;
  logic [3:0] sec_high;
  logic [3:0] sec_low;
  logic [3:0] tenths;
  logic       running;
  logic       expired;
  logic [2:0] lap_count;

  int vectorCount = 0;
  int missCount   = 0;

  logic [15:0] dispWord;
  assign dispWord = {minutes, sec_high, sec_low, tenths};

  lap_stopwatch #(
    .TICK_DIV  (4),
    .LAP_DEPTH (4),
    .MIN_MAX   (9)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .count_down (count_down),
    .load_min   (load_min),
    .load_sech  (load_sech),
    .load_secl  (load_secl),
    .load_tenth (load_tenth),
    .view_lap   (view_lap),
    .lap_sel    (lap_sel),
    .minutes    (minutes),
    .sec_high   (sec_high),
    .sec_low    (sec_low),
    .tenths     (tenths),
    .running    (running),
    .expired    (expired),
    .lap_count  (lap_count)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a stalled run.
  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 1000000 ns");
    $fatal(1, "[TB] timeout");
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on the control inputs, called on a falling edge.
  task automatic applyStimulus(input logic ss, input logic lp, input logic clr);
    start_stop = ss;
    lap        = lp;
    clear      = clr;
    @(negedge clock);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset      = 1'b1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    count_down = 1'b0;
    load_min   = 4'd0;
    load_sech  = 4'd0;
    load_secl  = 4'd0;
    load_tenth = 4'd0;
    view_lap   = 1'b0;
    lap_sel    = 2'd0;

    // Reset state
    waitCycles(2);
    checkOutput("resetDisplay", 32'(dispWord), 32'h0000);
    checkOutput("resetRunning", 32'(running), 32'd0);
    checkOutput("resetLapCount", 32'(lap_count), 32'd0);
    reset = 1'b0;

    // Up count, pause mid-window, partial-window resume
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(41);
    checkOutput("up40", 32'(dispWord), 32'h0010);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pauseRunning", 32'(running), 32'd0);
    waitCycles(100);
    checkOutput("pauseHold", 32'(dispWord), 32'h0010);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resumeRunning", 32'(running), 32'd1);
    waitCycles(2);
    checkOutput("resumeBeforeTick", 32'(dispWord), 32'h0010);
    waitCycles(1);
    checkOutput("resumePartialTick", 32'(dispWord), 32'h0011);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Laps at 0:00.3, 0:00.5, 0:00.8, 0:01.0, 0:01.4
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(12);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(7);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(11);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(7);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(15);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lapCountSat", 32'(lap_count), 32'd4);
    view_lap = 1'b1;
    lap_sel  = 2'd0;
    waitCycles(1);
    checkOutput("lapOldest", 32'(dispWord), 32'h0005);
    lap_sel = 2'd3;
    waitCycles(1);
    checkOutput("lapNewest", 32'(dispWord), 32'h0014);
    view_lap = 1'b0;

    // Pause requested on a tick edge keeps the ticked value
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pauseOnTickState", 32'(running), 32'd0);
    waitCycles(1);
    checkOutput("pauseOnTickValue", 32'(dispWord), 32'h0015);
    applyStimulus(1'b0, 1'b1, 1'b0);
    view_lap = 1'b1;
    lap_sel  = 2'd3;
    waitCycles(1);
    checkOutput("lapInPause", 32'(dispWord), 32'h0015);
    view_lap = 1'b0;

    // clear + start_stop + lap together in RUN
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("clearAllRunning", 32'(running), 32'd0);
    checkOutput("clearAllLapCount", 32'(lap_count), 32'd0);
    waitCycles(1);
    checkOutput("clearAllDisplay", 32'(dispWord), 32'h0000);

    // Partially filled buffer: unused index reads as zero
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(8);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("oneLapCount", 32'(lap_count), 32'd1);
    view_lap = 1'b1;
    lap_sel  = 2'd0;
    waitCycles(1);
    checkOutput("oneLapValue", 32'(dispWord), 32'h0002);
    lap_sel = 2'd1;
    waitCycles(1);
    checkOutput("emptyLapSlot", 32'(dispWord), 32'h0000);
    view_lap = 1'b0;
    lap_sel  = 2'd0;
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Wrap at 9:59.9
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(23997);
    checkOutput("maxTime", 32'(dispWord), 32'h9599);
    waitCycles(4);
    checkOutput("wrapDisplay", 32'(dispWord), 32'h0000);
    checkOutput("wrapRunning", 32'(running), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Countdown from 0:01.2
    count_down = 1'b1;
    load_min   = 4'd0;
    load_sech  = 4'd0;
    load_secl  = 4'd1;
    load_tenth = 4'd2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(47);
    checkOutput("downLastTenth", 32'(dispWord), 32'h0001);
    checkOutput("downNotExpired", 32'(expired), 32'd0);
    waitCycles(1);
    checkOutput("downExpired", 32'(expired), 32'd1);
    checkOutput("downStopped", 32'(running), 32'd0);
    waitCycles(1);
    checkOutput("downZero", 32'(dispWord), 32'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("expiredIgnoresStart", 32'(expired), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clearExpired", 32'(expired), 32'd0);

    // Preset clamp and borrow chain
    load_min   = 4'd12;
    load_sech  = 4'd0;
    load_secl  = 4'd0;
    load_tenth = 4'hC;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("presetClamp", 32'(dispWord), 32'h9009);
    waitCycles(40);
    checkOutput("borrowChain", 32'(dispWord), 32'h8599);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // All-zero preset expires immediately
    load_min   = 4'd0;
    load_tenth = 4'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("zeroPresetExpired", 32'(expired), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    count_down = 1'b0;

    // Asynchronous reset mid-run at 0:03.7
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(147);
    checkOutput("preResetTime", 32'(dispWord), 32'h0037);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetDisplay", 32'(dispWord), 32'h0000);
    checkOutput("asyncResetRunning", 32'(running), 32'd0);
    checkOutput("asyncResetLapCount", 32'(lap_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("postResetIdle", 32'(running), 32'd0);
    checkOutput("postResetDisplay", 32'(dispWord), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised stopwatch/countdown timer: the next generation of the team's single-channel stopwatch. It counts in BCD (M:SS.d) at a configurable tick rate and supports up-count and countdown modes, a pause/resume FSM, and a circular lap buffer with read-back. It sits between the debounced button/switch front end and the 7-segment display driver, which consumes the four BCD digit outputs.

## Interface
- TICK_DIV, 10_000_000, clock cycles per tenth-second tick (≥2)
- LAP_DEPTH, 4, lap buffer entries (power of two, ≥2); LW = $clog2(LAP_DEPTH)
- MIN_MAX, 9, largest minutes value (≤15)

- clock  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start_stop  in  1  single-cycle pulse; start/pause/resume
- lap  in  1  single-cycle pulse; capture current time into lap buffer
- clear  in  1  single-cycle pulse; return to IDLE
- count_down  in  1  mode select (1 = countdown); sampled only on IDLE→RUN
- load_min, load_sech, load_secl, load_tenth  in  4 each  countdown preset digits
- view_lap  in  1  1 = display stored lap instead of live time
- lap_sel  in  LW  lap index, 0 = oldest retained entry
- minutes, sec_high, sec_low, tenths  out  4 each  registered BCD display digits
- running  out  1  1 while in RUN
- expired  out  1  1 while in EXPIRED
- lap_count  out  LW+1  number of valid laps, saturates at LAP_DEPTH

## Operation
- Reset: state IDLE; digits, prescaler, lap buffer, write pointer, lap_count all 0; every output 0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. Priority: clear > start_stop > lap.
- IDLE: start_stop → RUN, prescaler cleared, mode latched. In countdown, the preset is loaded into the digits; an all-zero preset goes to EXPIRED instead of RUN.
- RUN: start_stop → PAUSE. PAUSE: start_stop → RUN. EXPIRED: start_stop and lap ignored.
- clear from any state → IDLE: digits 0, prescaler 0, lap_count 0, write pointer 0, expired 0.
- Prescaler counts 0..TICK_DIV-1 only in RUN. Tick occurs when it equals TICK_DIV-1, then it returns to 0. It holds its value in PAUSE so no fraction is lost on resume.
- Digit ranges: tenths 0-9, sec_low 0-9, sec_high 0-5, minutes 0..MIN_MAX.
- Up mode: ripple-increment per tick. MIN_MAX:59.9 wraps to 0:00.0 and RUN continues.
- Down mode: ripple-decrement per tick with borrow (0 → 9, sec_high 0 → 5). A tick that produces 0:00.0 moves the FSM to EXPIRED.
- Preset clamp at load: any digit above its range maximum loads as that maximum (e.g. load_tenth=0xC → 9, load_min=12 with MIN_MAX=9 → 9).
- Lap (RUN or PAUSE only):
  - Writes the pre-update digits of that cycle into the slot at the write pointer.
  - Write pointer increments mod LAP_DEPTH; lap_count increments, saturating at LAP_DEPTH.
  - When full, the oldest entry is overwritten.
- Lap read: physical slot = (wr_ptr − lap_count + lap_sel) mod LAP_DEPTH. If lap_sel ≥ lap_count, the selected value is 0:00.0.
- Display mux: view_lap=1 → selected lap; otherwise live digits.

## Timing
- Digit update is registered on the tick cycle.
- minutes/sec_high/sec_low/tenths register the mux output, so they lag internal digits by 1 cycle. view_lap and lap_sel changes also appear after 1 cycle.
- running and expired are decoded directly from the state register, with no added latency.
- start_stop and tick in the same cycle in RUN: the tick is applied and the state becomes PAUSE.
- Countdown tick reaching zero and start_stop in the same cycle: EXPIRED wins.
- lap coincident with a tick stores the pre-tick value.
- clear coincident with anything: IDLE; nothing is stored or counted.
- Reset asserted mid-operation clears outputs asynchronously, without waiting for a clock edge.
- Pulses longer than one cycle act as repeated events; the front end guarantees single-cycle pulses.

## Test plan
All scenarios use TICK_DIV=4, LAP_DEPTH=4, MIN_MAX=9.
- Up count/pause: start_stop, run 40 cycles → 0:01.0 displayed. Pause for 2 cycles into a tick window, wait 100 cycles → still 0:01.0. Resume → next tick arrives after the remaining prescaler cycles, not a full 4.
- Wrap: run to 9:59.9, one more tick → 0:00.0 with running=1.
- Countdown: count_down=1, preset 0:01.2, start → after 12 ticks (48 cycles) expired=1, running=0, display 0:00.0. start_stop ignored. clear → IDLE, expired=0. Preset tenths=0xC, min=12 → loads 9:00.9.
- Laps: laps at 0:00.3, 0:00.5, 0:00.8, 0:01.0, 0:01.4 → lap_count=4. view_lap with lap_sel=0 shows 0:00.5, lap_sel=3 shows 0:01.4. A lap captured while in PAUSE stores the held time.
- Simultaneous: clear+start_stop+lap in RUN → IDLE, lap_count=0, digits 0:00.0. start_stop on a tick cycle → PAUSE with incremented value.
- Reset mid-run at 0:03.7 → all outputs 0 before the next clock edge. After release, state is IDLE and lap_count=0.
